// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encodings, next-PC selects and fetch constants
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_BOOT = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_PEND = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        SEL_RST  = 2'd0,
        SEL_SEQ  = 2'd1,
        SEL_TGT  = 2'd2,
        SEL_PEND = 2'd3
    } pc_sel_e;

    localparam int INSTR_BYTES = 4;
    localparam int ALIGN_MASK  = 3;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: picks the next fetch address and forces word alignment
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  pc_sel_e         sel,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] tgt,
    input  logic [XLEN-1:0] pend_tgt,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] raw;

    // select the source, then clear the low address bits; PC+4 wraps naturally
    always_comb begin
        raw = sel == SEL_RST  ? RESET_VECTOR :
              sel == SEL_TGT  ? tgt :
              sel == SEL_PEND ? pend_tgt :
                                pc + XLEN'(INSTR_BYTES);
        next_pc = raw & ~XLEN'(ALIGN_MASK);
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC write/redirect/stall/flush sequencing for the 5-stage pipeline
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [XLEN-1:0]  PC,
    input  logic             BRANCH_TAKEN,
    input  logic [XLEN-1:0]  BRANCH_TARGET,
    input  logic             JUMP,
    input  logic [XLEN-1:0]  JUMP_TARGET,
    input  logic             IMEM_BUSYWAIT,
    input  logic             DMEM_BUSYWAIT,
    input  logic             LOAD_USE_HAZARD,
    output logic [XLEN-1:0]  NEXT_PC,
    output logic             PC_WE,
    output logic             STALL_IFID,
    output logic             FLUSH_IFID,
    output logic             FLUSH_IDEX,
    output logic [1:0]       SEQ_STATE,
    output logic [CNT_W-1:0] STALL_CYCLES
);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pc_sel_e         sel;
    logic            busy, redir;
    logic [XLEN-1:0] tgt;

    assign busy  = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
    assign redir = JUMP | BRANCH_TAKEN;
    assign tgt   = JUMP ? JUMP_TARGET : BRANCH_TARGET;

    // state, buffered redirect target and stall counter
    always_ff @(posedge CLK) begin
        state_q <= state_d;
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
    end

    // next state; a redirect seen while memory is busy is parked until it frees up
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        case (state_q)
            SEQ_BOOT: state_d = SEQ_RUN;
            SEQ_RUN: begin
                if (busy && redir) begin
                    state_d = SEQ_PEND;
                    pend_d  = tgt;
                end
            end
            SEQ_PEND: state_d = busy ? SEQ_PEND : SEQ_RUN;
            default:  state_d = SEQ_BOOT;
        endcase
        if ((state_q == SEQ_RUN || state_q == SEQ_PEND) && !PC_WE && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
        if (RESET) begin
            state_d = SEQ_BOOT;
            pend_d  = '0;
            cnt_d   = '0;
        end
    end

    // outputs; in RUN busy beats redirect beats load-use so older work is never dropped
    always_comb begin
        PC_WE      = 1'b0;
        sel        = SEL_SEQ;
        STALL_IFID = 1'b0;
        FLUSH_IFID = 1'b0;
        FLUSH_IDEX = 1'b0;
        if (RESET || state_q == SEQ_BOOT) begin
            PC_WE      = !RESET;
            sel        = SEL_RST;
            FLUSH_IFID = 1'b1;
            FLUSH_IDEX = 1'b1;
        end else if (state_q == SEQ_RUN) begin
            if (busy) begin
                STALL_IFID = 1'b1;
            end else if (redir) begin
                PC_WE      = 1'b1;
                sel        = SEL_TGT;
                FLUSH_IFID = 1'b1;
                FLUSH_IDEX = 1'b1;
            end else if (LOAD_USE_HAZARD) begin
                STALL_IFID = 1'b1;
                FLUSH_IDEX = 1'b1;
            end else begin
                PC_WE = 1'b1;
            end
        end else if (state_q == SEQ_PEND) begin
            if (busy) begin
                STALL_IFID = 1'b1;
            end else begin
                PC_WE      = 1'b1;
                sel        = SEL_PEND;
                FLUSH_IFID = 1'b1;
                FLUSH_IDEX = 1'b1;
            end
        end else begin
            sel        = SEL_RST;
            FLUSH_IFID = 1'b1;
            FLUSH_IDEX = 1'b1;
        end
    end

    pc_next_mux #(
        .XLEN        (XLEN),
        .RESET_VECTOR(RESET_VECTOR)
    ) u_mux (
        .sel     (sel),
        .pc      (PC),
        .tgt     (tgt),
        .pend_tgt(pend_q),
        .next_pc (NEXT_PC)
    );

    assign SEQ_STATE    = state_q;
    assign STALL_CYCLES = cnt_q;

endmodule
